// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-client round-robin arbiter sharing one registered-read single-port RAM
// Ports: clk/rst (sync, active-high); reqN_* valid/ready request channel (we, addr, wdata);
// rspN_valid/rspN_rdata one-cycle read response; ram_* drive/return for the external RAM.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic prio, rsp_pend, rsp_id;
  logic gnt, gid, gwe;
  logic [ADDR_W-1:0] gaddr;
  always_comb begin
    gnt        = ~rst & (req0_valid | req1_valid);
    gid        = (req0_valid & req1_valid) ? prio : req1_valid;
    gwe        = gid ? req1_we : req0_we;
    gaddr      = gnt ? (gid ? req1_addr : req0_addr) : '0;
    req0_ready = gnt & ~gid;
    req1_ready = gnt & gid;
    ram_we     = gnt & gwe;
    ram_waddr  = gaddr;
    ram_raddr  = gaddr;
    ram_wdata  = gnt ? (gid ? req1_wdata : req0_wdata) : '0;
    // a response pending across the edge into reset is dropped, not delivered
    rsp0_valid = ~rst & rsp_pend & ~rsp_id;
    rsp1_valid = ~rst & rsp_pend & rsp_id;
    rsp0_rdata = rsp0_valid ? ram_rdata : '0;
    rsp1_rdata = rsp1_valid ? ram_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      rsp_pend <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (gnt) begin
      prio     <= ~gid;
      rsp_pend <= ~gwe;
      rsp_id   <= gid;
    end else begin
      rsp_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus, RAM model and per-cycle reference check for ram_port_arbiter
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_we;
  logic [7:0] rsp0_rdata, rsp1_rdata, ram_wdata, ram_rdata;
  logic [5:0] ram_waddr, ram_raddr;
  int vectors = 0, miscompares = 0;

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // external RAM: registered read, write-first
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rdata <= (ram_we && ram_waddr == ram_raddr) ? ram_wdata : ram[ram_raddr];
  end

  function automatic logic [7:0] init_val(input int a);
    case (a)
      1: return 8'h11;
      2: return 8'h22;
      10: return 8'hA0;
      11: return 8'hA1;
      12: return 8'hA2;
      13: return 8'hA3;
      default: return 8'(a * 3 + 7);
    endcase
  endfunction

  // reference: shadow memory contents, whose turn it is, and the one response owed next cycle
  logic [7:0] shadow [64];
  bit m_prio = 0, m_pend = 0, m_id = 0;
  logic [7:0] m_data = '0;

  initial for (int i = 0; i < 64; i++) begin
    ram[i] = init_val(i);
    shadow[i] = init_val(i);
  end

  always @(posedge clk) begin
    bit id;
    if (rst) begin
      m_prio = 0;
      m_pend = 0;
    end else if (req0_valid || req1_valid) begin
      id = (req0_valid && req1_valid) ? m_prio : req1_valid;
      if (id ? req1_we : req0_we) begin
        shadow[id ? req1_addr : req0_addr] = id ? req1_wdata : req0_wdata;
        m_pend = 0;
      end else begin
        m_pend = 1;
        m_data = shadow[id ? req1_addr : req0_addr];
      end
      m_id = id;
      m_prio = !id;
    end else m_pend = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit g, id, r0, r1;
    g  = !rst && (req0_valid || req1_valid);
    id = (req0_valid && req1_valid) ? m_prio : req1_valid;
    r0 = !rst && m_pend && !m_id;
    r1 = !rst && m_pend && m_id;
    chk("m_req0_ready", 32'(req0_ready), 32'(g && !id));
    chk("m_req1_ready", 32'(req1_ready), 32'(g && id));
    chk("m_ram_we", 32'(ram_we), 32'(g && (id ? req1_we : req0_we)));
    chk("m_ram_waddr", 32'(ram_waddr), g ? 32'(id ? req1_addr : req0_addr) : 0);
    chk("m_ram_raddr", 32'(ram_raddr), g ? 32'(id ? req1_addr : req0_addr) : 0);
    chk("m_ram_wdata", 32'(ram_wdata), g ? 32'(id ? req1_wdata : req0_wdata) : 0);
    chk("m_rsp0_valid", 32'(rsp0_valid), 32'(r0));
    chk("m_rsp1_valid", 32'(rsp1_valid), 32'(r1));
    chk("m_rsp0_rdata", 32'(rsp0_rdata), r0 ? 32'(m_data) : 0);
    chk("m_rsp1_rdata", 32'(rsp1_rdata), r1 ? 32'(m_data) : 0);
  end

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit v, input bit we, input int a, input int d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = 6'(a); req0_wdata = 8'(d);
    end else begin
      req1_valid = v; req1_we = we; req1_addr = 6'(a); req1_wdata = 8'(d);
    end
  endtask

  initial begin
    // reset held two cycles with a request pending
    drive(0, 1, 0, 7, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_rsp0", 32'(rsp0_valid), 0);
      next();
    end
    // first conflict after reset goes to requester 0, then strict alternation
    rst = 0;
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      chk("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      if (i > 0) chk("cont_rsp", i % 2 ? 32'(rsp0_rdata) : 32'(rsp1_rdata), i % 2 ? 32'h11 : 32'h22);
      next();
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("cont_last_rsp1", 32'(rsp1_rdata), 32'h22);
    next();
    // single write then read-back on requester 0
    drive(0, 1, 1, 5, 8'hA5);
    @(negedge clk);
    chk("wr_ram_we", 32'(ram_we), 1);
    next();
    drive(0, 1, 0, 5, 0);
    next();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_rsp0_valid", 32'(rsp0_valid), 1);
    chk("rd_rsp0_rdata", 32'(rsp0_rdata), 32'hA5);
    chk("rd_rsp1_valid", 32'(rsp1_valid), 0);
    next();
    // cross-requester write-then-read at the top address
    drive(1, 1, 1, 63, 8'h3C);
    next();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 63, 0);
    next();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("coh_rsp0_rdata", 32'(rsp0_rdata), 32'h3C);
    next();
    // lone requester streaming reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 1, 0, 10 + i, 0); else drive(1, 0, 0, 0, 0);
      @(negedge clk);
      if (i < 4) chk("lone_ready1", 32'(req1_ready), 1);
      if (i > 0) chk("lone_rsp1", 32'(rsp1_rdata), 32'hA0 + 32'(i - 1));
      next();
    end
    // read accepted right before reset yields no response, priority back to 0
    drive(0, 1, 0, 20, 0);
    next();
    drive(0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    chk("rstmid_rsp0", 32'(rsp0_valid), 0);
    next();
    rst = 0;
    @(negedge clk);
    chk("rstmid_rsp0_after", 32'(rsp0_valid), 0);
    next();
    drive(0, 1, 0, 3, 0);
    drive(1, 1, 0, 4, 0);
    @(negedge clk);
    chk("rstmid_prio", 32'(req0_ready), 1);
    next();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) next();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester round-robin arbiter that shares one 64x8 single-port RAM (separate read/write address inputs, registered read data, write-first on address match) between two clients. Each client uses a valid/ready request channel and gets a read-response strobe. The block drives the RAM's write-enable, both addresses and write data, and routes the RAM's registered read data back to the requester that issued the read. It sits between client logic and the RAM macro; the RAM is external to this block.

Parameters:
ADDR_W, 6, RAM address width (64 entries)
DATA_W, 8, RAM data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  request address
req0_wdata  in  DATA_W  write data
rsp0_valid  out  1  read data valid for requester 0
rsp0_rdata  out  DATA_W  read data for requester 0
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_W  RAM write address
ram_raddr  out  ADDR_W  RAM read address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM registered read data (valid the cycle after the address is presented)

Behaviour:
- State: prio (1 bit, requester preferred on conflict), rsp_pend (1 bit), rsp_id (1 bit).
- Reset (rst=1 at edge): prio=0, rsp_pend=0, rsp_id=0. While rst=1: req0_ready=req1_ready=0, ram_we=0.
- Grant (combinational, same cycle): only req0 valid -> grant 0; only req1 valid -> grant 1; both valid -> grant prio; neither -> no grant. reqN_ready=1 only for the granted requester. At most one request is accepted per cycle.
- Ready depends on valid; clients must not make valid depend on ready. A client holds valid/we/addr/wdata stable until ready.
- RAM drive on grant: ram_waddr=ram_raddr=granted addr, ram_wdata=granted wdata, ram_we=granted we. With no grant: ram_we=0, addresses and wdata=0.
- Prio update at edge: after a grant, prio = ~granted id. With no grant, prio holds. A lone requester is granted every cycle (throughput 1/cycle). Under contention, grants alternate strictly. There is no starvation.
- Read response: a read accepted in cycle N sets rsp_pend=1 and rsp_id=id at the edge. In cycle N+1, rsp<id>_valid=1 and rsp<id>_rdata=ram_rdata. The other rsp valid is 0. Latency is exactly 1 cycle. Responses cannot be back-pressured.
- Writes produce no response. Accepting a write clears rsp_pend at the edge.
- rspN_rdata=0 whenever rspN_valid=0.
- Back-to-back: a write to A in cycle N followed by a read of A in cycle N+1 (either requester) returns the new data in N+2. Responses to pipelined reads in consecutive cycles appear in consecutive cycles, in order.
- Reset mid-operation: a read accepted the cycle before rst is asserted produces no response (rsp_pend cleared). The request is lost and the client must reissue it.
- Address wrap: addr passes unmodified. Address 63 is valid and there is no range check.

Test Plan:
- Reset: assert rst 2 cycles with req0_valid=1 -> req0_ready=0, ram_we=0, rsp0/1_valid=0. After release, first conflict grants requester 0.
- Single write/read: req0 write addr=5 data=0xA5, then req0 read addr=5 -> ram_we=1 in write cycle. rsp0_valid=1, rsp0_rdata=0xA5 exactly 1 cycle after read accept. rsp1_valid stays 0.
- Contention: both valid for 4 cycles, req0 reads addr 1, req1 reads addr 2 (preloaded 0x11, 0x22) -> grants 0,1,0,1. Responses alternate rsp0=0x11, rsp1=0x22 one cycle later.
- Cross-requester coherence: req1 writes addr=63 data=0x3C, next cycle req0 reads 63 -> rsp0_rdata=0x3C.
- Lone requester: req1_valid=1 continuously with reads of addr 10..13 -> req1_ready=1 every cycle. Four consecutive rsp1_valid pulses carry the contents of addr 10..13 in order.
- Reset mid-read: req0 read accepted, rst=1 next cycle -> rsp0_valid stays 0, prio=0 afterward.
